// File: rtl/snake_block_plotter.sv
// Pixel back end for snake drawing commands: expands cell draws into 16
// plots and screen clears into a full 160x120 black fill.
module snake_block_plotter #(
  parameter int CELL_W = 40,
  parameter int CELL_H = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_cell_x,
  input  logic [4:0] req_cell_y,
  input  logic [2:0] req_colour,
  output logic       req_err,
  input  logic       clear_start,
  output logic       clear_done,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] X_LAST = 8'(4 * CELL_W - 1);
  localparam logic [6:0] Y_LAST = 7'(4 * CELL_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CLEAR,
    CDONE
  } state_t;

  state_t      state;
  logic [5:0]  cell_x;
  logic [4:0]  cell_y;
  logic [2:0]  colour;
  logic        bad;
  logic [3:0]  p;
  logic [7:0]  cx;
  logic [6:0]  cy;
  logic        pend;
  logic        req_bad;

  assign req_bad = (req_cell_x >= 6'(CELL_W)) ||
                   (req_cell_y >= 5'(CELL_H));

  assign req_ready = (state == IDLE) && !pend && !clear_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cell_x <= '0;
      cell_y <= '0;
      colour <= '0;
      bad    <= 1'b0;
      p      <= '0;
      cx     <= '0;
      cy     <= '0;
      pend   <= 1'b0;
    end else begin
      if (clear_start)
        pend <= 1'b1;
      case (state)
        IDLE: begin
          // a clear request wins over a draw offered in the same cycle
          if (pend || clear_start) begin
            state <= CLEAR;
            cx    <= '0;
            cy    <= '0;
            pend  <= 1'b0;
          end else if (req_valid && req_ready) begin
            state  <= DRAW;
            cell_x <= req_cell_x;
            cell_y <= req_cell_y;
            colour <= req_colour;
            bad    <= req_bad;
            p      <= '0;
          end
        end
        DRAW: begin
          p <= p + 4'd1;
          if (p == 4'd15)
            state <= IDLE;
        end
        CLEAR: begin
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy    <= '0;
              state <= CDONE;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end
        CDONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      DRAW: begin
        vga_x      = {cell_x, 2'b00} + {6'b0, p[1:0]};
        vga_y      = {cell_y, 2'b00} + {5'b0, p[3:2]};
        vga_colour = colour;
        vga_plot   = !bad;
      end
      CLEAR: begin
        vga_x    = cx;
        vga_y    = cy;
        vga_plot = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_err    = (state == DRAW) && bad && (p == 4'd0);
  assign clear_done = (state == CDONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_snake_block_plotter.sv
// Directed bench for snake_block_plotter: draws, corner cells,
// full clears, request priority and reset during a clear.
module tb_snake_block_plotter;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_cell_x;
  logic [4:0] req_cell_y;
  logic [2:0] req_colour;
  logic       req_err;
  logic       clear_start;
  logic       clear_done;
  logic       busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int checks;
  int failures;

  snake_block_plotter #(
    .CELL_W(40),
    .CELL_H(30)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cell_x (req_cell_x),
    .req_cell_y (req_cell_y),
    .req_colour (req_colour),
    .req_err    (req_err),
    .clear_start(clear_start),
    .clear_done (clear_done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int x, input int y, input int c);
    req_cell_x = 6'(x);
    req_cell_y = 5'(y);
    req_colour = 3'(c);
    req_valid  = 1'b1;
    #1;
    chk("acc_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // checks the 16 cycles after an accept; pulses clear_start at pulse_at
  task automatic check_cell(input int x, input int y, input int c,
                            input int pulse_at);
    bit ok;
    ok = (x < 40) && (y < 30);
    for (int i = 0; i < 16; i++) begin
      chk("cell_x", vga_x, (4 * x + i % 4) & 255);
      chk("cell_y", vga_y, (4 * y + i / 4) & 127);
      chk("cell_col", vga_colour, c);
      chk("cell_plot", vga_plot, ok ? 1 : 0);
      chk("cell_err", req_err, (i == 0 && !ok) ? 1 : 0);
      chk("cell_ready", req_ready, 0);
      chk("cell_busy", busy, 1);
      clear_start = (i == pulse_at);
      tick();
    end
    clear_start = 1'b0;
  endtask

  initial begin
    bit seen [0:19199];
    int plots, order_bad, col_bad, dup, early, n, bad_acc, dones;

    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_cell_x  = '0;
    req_cell_y  = '0;
    req_colour  = '0;
    clear_start = 1'b0;
    tick();
    tick();

    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_col", vga_colour, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_err", req_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b1;
    tick();

    accept(2, 3, 4);
    check_cell(2, 3, 4, -1);
    chk("draw_ready17", req_ready, 1);
    chk("draw_idle_plot", vga_plot, 0);

    accept(39, 29, 7);
    check_cell(39, 29, 7, -1);
    chk("corner_ready", req_ready, 1);

    accept(40, 0, 3);
    check_cell(40, 0, 3, -1);
    chk("oor_x_ready", req_ready, 1);

    accept(0, 30, 6);
    check_cell(0, 30, 6, -1);
    chk("oor_y_ready", req_ready, 1);

    clear_start = 1'b1;
    #1;
    chk("clr_ready_low", req_ready, 0);
    tick();
    clear_start = 1'b0;
    plots = 0; order_bad = 0; col_bad = 0; dup = 0; early = 0;
    for (int i = 0; i < 19200; i++) begin
      if (vga_plot === 1'b1) begin
        plots++;
        if (vga_x < 160 && vga_y < 120) begin
          if (seen[vga_y * 160 + vga_x]) dup++;
          seen[vga_y * 160 + vga_x] = 1'b1;
        end
      end
      if (vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160)) order_bad++;
      if (vga_colour !== 3'd0) col_bad++;
      if (clear_done !== 1'b0) early++;
      tick();
    end
    chk("clr_plots", plots, 19200);
    chk("clr_order", order_bad, 0);
    chk("clr_colour", col_bad, 0);
    chk("clr_dup", dup, 0);
    chk("clr_early_done", early, 0);
    chk("clr_done", clear_done, 1);
    chk("clr_done_plot", vga_plot, 0);
    chk("clr_done_busy", busy, 1);
    tick();
    chk("clr_done_once", clear_done, 0);
    chk("clr_idle_ready", req_ready, 1);
    chk("clr_idle_busy", busy, 0);

    req_cell_x  = 6'd5;
    req_cell_y  = 5'd6;
    req_colour  = 3'd2;
    req_valid   = 1'b1;
    clear_start = 1'b1;
    #1;
    chk("sim_ready_low", req_ready, 0);
    tick();
    clear_start = 1'b0;
    n = 0;
    bad_acc = 0;
    while (clear_done !== 1'b1 && n < 20000) begin
      if (vga_plot === 1'b1 && vga_colour !== 3'd0) bad_acc++;
      if (req_ready !== 1'b0) bad_acc++;
      tick();
      n++;
    end
    chk("sim_done", clear_done, 1);
    chk("sim_cycles", n, 19200);
    chk("sim_no_accept", bad_acc, 0);
    tick();
    chk("sim_ready_after", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check_cell(5, 6, 2, -1);
    chk("sim_end_ready", req_ready, 1);

    accept(1, 1, 5);
    check_cell(1, 1, 5, 4);
    chk("cdd_ready_pend", req_ready, 0);
    chk("cdd_idle_busy", busy, 0);
    chk("cdd_idle_plot", vga_plot, 0);
    tick();
    chk("cdd_clr_plot", vga_plot, 1);
    chk("cdd_clr_x", vga_x, 0);
    chk("cdd_clr_y", vga_y, 0);
    n = 0; dones = 0; plots = 0;
    while (dones < 2 && n < 38500) begin
      if (vga_plot === 1'b1) plots++;
      if (clear_done === 1'b1) dones++;
      clear_start = (n == 100);
      tick();
      n++;
    end
    clear_start = 1'b0;
    chk("cdd_dones", dones, 2);
    chk("cdd_plots", plots, 38400);
    chk("cdd_ready_end", req_ready, 1);

    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 5000; i++) tick();
    chk("rmc_x", vga_x, 40);
    chk("rmc_y", vga_y, 31);
    chk("rmc_plot", vga_plot, 1);
    rst = 1'b0;
    tick();
    chk("rmc_plot_off", vga_plot, 0);
    chk("rmc_done", clear_done, 0);
    chk("rmc_busy", busy, 0);
    chk("rmc_x0", vga_x, 0);
    rst = 1'b1;
    #1;
    chk("rmc_ready", req_ready, 1);
    early = 0;
    for (int i = 0; i < 40; i++) begin
      if (clear_done !== 1'b0 || vga_plot !== 1'b0) early++;
      tick();
    end
    chk("rmc_quiet", early, 0);

    accept(0, 0, 1);
    check_cell(0, 0, 1, -1);
    chk("rmc_draw_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_block_plotter.md
# snake_block_plotter

Pixel back end for the snake game's drawing commands. It accepts one-cell draw requests (snake segment, head, food, erase) and screen-clear requests, and expands each into per-pixel writes for the 160x120, 3-bit-colour VGA adapter. A 4x4-pixel cell is written as 16 plots. A full-screen black fill is written as 19200 plots. `clear_done` is the one-cycle pulse that the movement controller consumes as `fromBlack`.

## Interface
Parameters:
- CELL_W, 40: grid width in cells; screen width is 4*CELL_W = 160.
- CELL_H, 30: grid height in cells; screen height is 4*CELL_H = 120.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- req_valid  in  1  cell draw request.
- req_ready  out  1  high when a request can be accepted.
- req_cell_x  in  6  cell column, 0..CELL_W-1.
- req_cell_y  in  5  cell row, 0..CELL_H-1.
- req_colour  in  3  cell colour.
- req_err  out  1  one-cycle pulse when an out-of-range request is accepted.
- clear_start  in  1  request a full-screen black fill; pulse or level.
- clear_done  out  1  one-cycle pulse after the last clear pixel.
- busy  out  1  high in DRAW, CLEAR and CDONE.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe for the VGA adapter.

## Operation
- States: IDLE, DRAW, CLEAR, CDONE.
- All outputs are decoded from registered state only: state, latched cell, latched colour, pixel counter `p[3:0]`, clear counters `cx[7:0]` and `cy[6:0]`, and the `pend` flag.
- `req_ready = (state==IDLE) && !pend && !clear_start`.
- **Clear request capture:**
  - A `clear_start` seen in any state sets `pend`.
  - In IDLE, if `pend` or `clear_start` is set: go to CLEAR, zero `cx`/`cy`, clear `pend`.
  - A clear request has priority over `req_valid` in the same cycle.
- **Draw accept (IDLE):**
  - On `req_valid && req_ready`: latch cell and colour, set `p=0`, go to DRAW.
  - If `req_cell_x>=CELL_W` or `req_cell_y>=CELL_H`: `req_err` pulses in the cycle after accept and DRAW still runs 16 cycles with `vga_plot` held low.
- **DRAW:**
  - `vga_x = 4*cell_x + p[1:0]`, `vga_y = 4*cell_y + p[3:2]`, `vga_colour` = latched colour.
  - `vga_plot = 1` unless the request was flagged out of range.
  - `p` increments each cycle.
  - At `p==15`: go to IDLE.
  - Pixel order is row-major within the cell: (0,0), (1,0), ..., (3,3).
- **CLEAR:**
  - `vga_x=cx`, `vga_y=cy`, `vga_colour=0`, `vga_plot=1`.
  - `cx` increments each cycle; when `cx` wraps 159→0, `cy` increments.
  - At (159,119): go to CDONE.
- **CDONE:** `clear_done=1`, `vga_plot=0`; go to IDLE.
- A `clear_start` arriving during CLEAR is latched in `pend` and runs a second full clear afterwards.
- Outside DRAW/CLEAR: `vga_plot=0`, `vga_x=0`, `vga_y=0`, `vga_colour=0`.
- Arithmetic:
  - `4*cell_x` is a 2-bit left shift into 8 bits; the maximum is 4*39+3 = 159.
  - `4*cell_y` is computed in 7 bits; the maximum is 119.
  - No other overflow is possible within range.

## Timing
- **Reset:** `rst` low at a rising edge gives, after that edge:
  - state=IDLE, `pend=0`, all counters 0.
  - `vga_plot=0`, `vga_x=0`, `vga_y=0`, `vga_colour=0`.
  - `clear_done=0`, `req_err=0`, `busy=0`, `req_ready=1` (while `clear_start` is low).
  - This applies mid-DRAW or mid-CLEAR too: the operation is abandoned with no `clear_done`.
- **Draw latency:** for an accept at edge E0, pixels 0..15 appear in cycles E0+1..E0+16. `req_ready` is high again in cycle E0+17.
- **Draw throughput:** 17 cycles per cell; there is no back-to-back accept.
- **Clear:** for a start seen at edge E0, plots occupy cycles E0+1..E0+19200. `clear_done` is high in cycle E0+19201, and IDLE follows at E0+19202.
- `req_valid` may stay high while `req_ready` is low; the request is held by the initiator and not lost.
- `req_cell_*` and `req_colour` are sampled only on the accept edge.

## Test plan
- **Reset, then single draw:** release reset; cell (2,3), colour 3'b100 → 16 plots with x 8..11, y 12..15, colour 4, in row-major order in cycles 1..16. `req_ready` low for 16 cycles, high in cycle 17.
- **Corner cell:** cell (39,29) → final pixel (159,119) with no wrap. Cell (40,0) → `req_err` pulse and zero plots.
- **Full clear:** `clear_start` for one cycle → exactly 19200 plots, all colour 0, covering each (x,y) once. `clear_done` asserted exactly once, in cycle 19201.
- **Simultaneous requests:** `clear_start` and `req_valid` in the same IDLE cycle → clear runs first. The request is accepted only after `clear_done`, and `req_valid` stays high throughout.
- **Clear during draw:** `clear_start` pulsed mid-DRAW → the draw completes all 16 pixels, then the clear starts with no IDLE accept in between. A second pulse during CLEAR gives two `clear_done` pulses in total.
- **Reset mid-CLEAR:** `rst` low at pixel 5000 → `vga_plot=0` on the next cycle and no `clear_done`. After release, `req_ready=1`.
